// File: rtl/sys1_input_cond.sv
// Input conditioner for the SEGA System 1 core: debounces the merged joystick word,
// shapes coin insertions into frame-counted pulses and maps controls onto active-low INP bytes.
module sys1_input_cond #(
   parameter int DEBOUNCE_CYC    = 48000,
   parameter int COIN_MIN_FRAMES = 3,
   parameter int COIN_GAP_FRAMES = 3
) (
   input  logic        clk48M,
   input  logic        reset,
   input  logic [11:0] joy,
   input  logic        mode_wm,
   input  logic        vblank,
   output logic [7:0]  INP0,
   output logic [7:0]  INP1,
   output logic [7:0]  INP2,
   output logic        coin_busy
);

   localparam int PW   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int FMAX = (COIN_MIN_FRAMES > COIN_GAP_FRAMES) ? COIN_MIN_FRAMES : COIN_GAP_FRAMES;
   localparam int FW   = $clog2(FMAX + 1);
   localparam logic [PW-1:0] PS_LAST  = PW'(DEBOUNCE_CYC - 1);
   localparam logic [FW-1:0] MIN_LAST = FW'(COIN_MIN_FRAMES - 1);
   localparam logic [FW-1:0] GAP_LAST = FW'(COIN_GAP_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } coin_state_e;

   logic [PW-1:0] ps_q, ps_d;
   logic [11:0]   h0_q, h0_d, h1_q, h1_d, deb_q, deb_d;
   logic          deb11_q, deb11_d, vb_q, vb_d;
   coin_state_e   state_q, state_d;
   logic [FW-1:0] fc_q, fc_d;
   logic          pend_q, pend_d;
   logic [7:0]    inp0_q, inp0_d, inp1_q, inp1_d, inp2_q, inp2_d;
   logic          coin_busy_q, coin_busy_d;
   logic          stick_s, ftick_s, cedge_s, coin_act_s;
   logic [11:0]   agree_s;
   logic [7:0]    pad_s;

   // Sample prescaler and three-sample debounce; a bit only moves when joy, h0 and h1 all agree.
   always_comb begin
      stick_s = (ps_q == PS_LAST);
      agree_s = ~(joy ^ h0_q) & ~(h0_q ^ h1_q);
      ps_d    = ps_q;
      h0_d    = h0_q;
      h1_d    = h1_q;
      deb_d   = deb_q;
      if (stick_s) begin
         ps_d  = {PW{1'b0}};
         h0_d  = joy;
         h1_d  = h0_q;
         deb_d = (deb_q & ~agree_s) | (joy & agree_s);
      end else begin
         ps_d  = ps_q + PW'(1);
      end
      deb11_d = deb_q[11];
      vb_d    = vblank;
      ftick_s = vblank & ~vb_q;
      cedge_s = deb_q[11] & ~deb11_q;
   end

   // Coin pulse shaper: at most one insertion is queued while a pulse or its gap is running.
   always_comb begin
      state_d = state_q;
      fc_d    = fc_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (cedge_s || pend_q) begin
               state_d = ACTIVE;
               fc_d    = {FW{1'b0}};
               pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            pend_d = pend_q | cedge_s;
            if (ftick_s) begin
               if (fc_q == MIN_LAST) begin
                  state_d = GAP;
                  fc_d    = {FW{1'b0}};
               end else begin
                  fc_d    = fc_q + FW'(1);
               end
            end else begin
               fc_d = fc_q;
            end
         end
         GAP: begin
            pend_d = pend_q | cedge_s;
            if (ftick_s) begin
               if (fc_q == GAP_LAST) begin
                  state_d = IDLE;
                  fc_d    = {FW{1'b0}};
               end else begin
                  fc_d    = fc_q + FW'(1);
               end
            end else begin
               fc_d = fc_q;
            end
         end
         default: begin
            state_d = IDLE;
            fc_d    = {FW{1'b0}};
            pend_d  = 1'b0;
         end
      endcase
      coin_act_s  = (state_q == ACTIVE);
      coin_busy_d = (state_q != IDLE);
   end

   // Layout mapping; Water Match uses the right stick on the low nibble and trigger on INP2[7:6].
   always_comb begin
      if (mode_wm) begin
         pad_s  = {deb_q[1], deb_q[0], deb_q[3], deb_q[2], deb_q[5], deb_q[4], deb_q[7], deb_q[6]};
         inp2_d = ~{deb_q[8], deb_q[8], deb_q[10], deb_q[9], 3'b000, coin_act_s};
      end else begin
         pad_s  = {deb_q[1], deb_q[0], deb_q[3], deb_q[2], 1'b0, deb_q[5], deb_q[4], deb_q[6]};
         inp2_d = ~{2'b00, deb_q[10], deb_q[9], 3'b000, coin_act_s};
      end
      inp0_d = ~pad_s;
      inp1_d = ~pad_s;
   end

   // State and output registers.
   always_ff @(posedge clk48M) begin
      if (reset) begin
         ps_q        <= {PW{1'b0}};
         h0_q        <= 12'h000;
         h1_q        <= 12'h000;
         deb_q       <= 12'h000;
         deb11_q     <= 1'b0;
         vb_q        <= 1'b0;
         state_q     <= IDLE;
         fc_q        <= {FW{1'b0}};
         pend_q      <= 1'b0;
         inp0_q      <= 8'hFF;
         inp1_q      <= 8'hFF;
         inp2_q      <= 8'hFF;
         coin_busy_q <= 1'b0;
      end else begin
         ps_q        <= ps_d;
         h0_q        <= h0_d;
         h1_q        <= h1_d;
         deb_q       <= deb_d;
         deb11_q     <= deb11_d;
         vb_q        <= vb_d;
         state_q     <= state_d;
         fc_q        <= fc_d;
         pend_q      <= pend_d;
         inp0_q      <= inp0_d;
         inp1_q      <= inp1_d;
         inp2_q      <= inp2_d;
         coin_busy_q <= coin_busy_d;
      end
   end

   assign INP0      = inp0_q;
   assign INP1      = inp1_q;
   assign INP2      = inp2_q;
   assign coin_busy = coin_busy_q;

endmodule
